// File: rtl/pipeline_insnfetch_q.sv
// rtl/pipeline_insnfetch_q.sv - instruction fetch stage with prefetch queue; optional same-cycle bypass via IFQ_BYPASS_EN
module pipeline_insnfetch_q #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        stall_in,
    output logic [31:0] insn,
    output logic [31:0] insnPC,
    output logic        insn_valid,
    output logic        placeholder_insn
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(QUEUE_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] q_insn [QUEUE_DEPTH];
    logic [31:0] q_pc   [QUEUE_DEPTH];

    logic [CNT_W-1:0] live_inflight;
    logic [CNT_W:0]   credit_sum;
    logic             grant;
    logic             resp_live;
    logic             bypass;
    logic             queue_valid;
    logic             push;
    logic             pop;

    // Credit accounting: queued entries plus live (non-dropped) reads must fit in the queue
    always_comb begin
        live_inflight = outstanding_q - drop_cnt_q;
        credit_sum    = {1'b0, count_q} + {1'b0, live_inflight};
        mem_req       = !RST && !redirect_en && ({1'b0, outstanding_q} < DEPTH_W)
                        && (credit_sum < DEPTH_W);
        mem_addr      = fetch_pc_q;
        grant         = mem_req && mem_gnt;
        resp_live     = mem_rvalid && (drop_cnt_q == '0) && !redirect_en;
    end

`ifdef IFQ_BYPASS_EN
    assign bypass = !RST && (count_q == '0) && resp_live && !stall_in;
`else
    assign bypass = 1'b0;
`endif

    // Decode-side outputs: queue head, or the live response itself when bypassing
    always_comb begin
        queue_valid      = (count_q != '0) && !redirect_en;
        insn_valid       = queue_valid || bypass;
        placeholder_insn = !insn_valid;
        insn             = 32'h0;
        insnPC           = 32'h0;
        if (bypass) begin
            insn   = mem_rdata;
            insnPC = resp_pc_q;
        end else if (queue_valid) begin
            insn   = q_insn[rd_ptr_q];
            insnPC = q_pc[rd_ptr_q];
        end
        pop  = queue_valid && !stall_in;
        push = resp_live && !bypass;
    end

    // Next-state: redirect flushes the queue and turns every in-flight read into a drop
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(mem_rvalid);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        if (redirect_en) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_cnt_d = outstanding_q - CNT_W'(mem_rvalid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_live) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (mem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage; contents are qualified by count_q so no reset is needed
    always_ff @(posedge CLK) begin
        if (push) begin
            q_insn[wr_ptr_q] <= mem_rdata;
            q_pc[wr_ptr_q]   <= resp_pc_q;
        end
    end
endmodule
